// File: rtl/ipsum_push_sched.sv
// Ipsum push scheduler: fetches partial-sum words from the GLB and pushes them
// into per-FIFO ipsum queues, one read at a time, round-robin across FIFOs.
module ipsum_push_sched #(
  parameter int NUM_FIFO = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         tile_len,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   fifo_stride,
  output logic                busy,
  output logic                done,
  output logic                glb_rd_req,
  output logic [ADDR_W-1:0]   glb_rd_addr,
  input  logic                glb_rd_gnt,
  input  logic                glb_rd_valid,
  input  logic [31:0]         glb_rd_data,
  input  logic [NUM_FIFO-1:0] fifo_empty,
  input  logic [NUM_FIFO-1:0] fifo_full,
  output logic [NUM_FIFO-1:0] fifo_push_en,
  output logic                fifo_push_mod,
  output logic [31:0]         fifo_push_data
);

  localparam int SEL_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, PUSH, DONE} state_t;

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    rr_reg, sel_reg, scan_pick, sel_inc;
  logic [15:0]         rem_reg  [NUM_FIFO];
  logic [15:0]         widx_reg [NUM_FIFO];
  logic [31:0]         data_reg;
  logic [ADDR_W-1:0]   base_reg, stride_reg, rd_addr_calc;
  logic [NUM_FIFO-1:0] eligible, pending;
  logic                scan_found;
  logic [15:0]         rem_sel, widx_sel;
  logic                push_burst;

  // A burst needs an empty FIFO (two free slots); a single tail word only needs room.
  generate
    for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_fifo
      assign eligible[gi] = ((rem_reg[gi] >= 16'd2) && fifo_empty[gi]) ||
                            ((rem_reg[gi] == 16'd1) && !fifo_full[gi]);
      assign pending[gi]  = (rem_reg[gi] != 16'd0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_reg[gi]  <= '0;
          widx_reg[gi] <= '0;
        end else if (state_reg == IDLE && start) begin
          rem_reg[gi]  <= tile_len;
          widx_reg[gi] <= '0;
        end else if (state_reg == PUSH && sel_reg == SEL_W'(gi)) begin
          rem_reg[gi]  <= rem_reg[gi] - (push_burst ? 16'd2 : 16'd1);
          widx_reg[gi] <= widx_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  // First eligible FIFO starting at rr, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    scan_found = 1'b0;
    scan_pick  = rr_reg;
    for (int k = 0; k < NUM_FIFO; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= NUM_FIFO) idx = idx - NUM_FIFO;
      if (!scan_found && eligible[idx]) begin
        scan_found = 1'b1;
        scan_pick  = SEL_W'(idx);
      end
    end
  end

  assign rem_sel      = rem_reg[sel_reg];
  assign widx_sel     = widx_reg[sel_reg];
  assign push_burst   = (rem_sel >= 16'd2);
  assign sel_inc      = (sel_reg == SEL_W'(NUM_FIFO - 1)) ? '0 : sel_reg + 1'b1;
  assign rd_addr_calc = base_reg + ADDR_W'(sel_reg) * stride_reg + ADDR_W'({widx_sel, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_reg     <= '0;
      sel_reg    <= '0;
      data_reg   <= '0;
      base_reg   <= '0;
      stride_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        base_reg   <= base_addr;
        stride_reg <= fifo_stride;
      end
      if (state_reg == SCAN && scan_found) sel_reg <= scan_pick;
      if (state_reg == WAIT && glb_rd_valid) data_reg <= glb_rd_data;
      if (state_reg == PUSH) rr_reg <= sel_inc;
    end
  end

  always_comb begin
    state_next     = state_reg;
    busy           = 1'b1;
    done           = 1'b0;
    glb_rd_req     = 1'b0;
    glb_rd_addr    = '0;
    fifo_push_en   = '0;
    fifo_push_mod  = 1'b0;
    fifo_push_data = '0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = SCAN;
      end
      SCAN: begin
        if (pending == '0)   state_next = DONE;
        else if (scan_found) state_next = REQ;
      end
      REQ: begin
        glb_rd_req  = 1'b1;
        glb_rd_addr = rd_addr_calc;
        if (glb_rd_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (glb_rd_valid) state_next = PUSH;
      end
      PUSH: begin
        fifo_push_en[sel_reg] = 1'b1;
        fifo_push_mod         = push_burst;
        fifo_push_data        = data_reg;
        state_next            = SCAN;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
